w_74hc00_tester: RTL



---
 rtl/w_74hc00_tester.sv | 121 ++++++++++++
 1 files changed

// File: rtl/w_74hc00_tester.sv
// Self-test sweeper for a quad 2-input NAND: drives all 256 A/B vectors, checks
// the synchronized Y bus against ~(A&B) and reports a fault mask, first failing vector and error count.
module w_74hc00_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_y_in,
  output logic [3:0] o_a_out,
  output logic [3:0] o_b_out,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask,
  output logic [7:0] o_first_fail,
  output logic [8:0] o_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0] r_state;
  logic [7:0] r_vec;
  logic [7:0] r_cnt;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_fail_mask;
  logic [7:0] r_first_fail;
  logic [8:0] r_err_cnt;
  logic       r_pass;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_mis;
  logic       w_compare;

  assign w_a       = r_vec[7:4];
  assign w_b       = r_vec[3:0];
  assign w_mis     = r_sync2 ^ ~(w_a & w_b);
  assign w_compare = (r_state == S_RUN) && (r_cnt == 8'd0);

  // Y_IN is asynchronous to the clock, so it is only ever used after two flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= i_y_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_vec        <= 8'd0;
      r_cnt        <= 8'd0;
      r_fail_mask  <= 4'd0;
      r_first_fail <= 8'd0;
      r_err_cnt    <= 9'd0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_RUN;
            r_vec        <= 8'd0;
            r_cnt        <= CNT_RELOAD;
            r_fail_mask  <= 4'd0;
            r_first_fail <= 8'd0;
            r_err_cnt    <= 9'd0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_compare) begin
            r_fail_mask <= r_fail_mask | w_mis;
            // First-fail capture looks at the count before this vector's increment.
            if (w_mis != 4'd0) begin
              r_err_cnt <= r_err_cnt + 9'd1;
              if (r_err_cnt == 9'd0) r_first_fail <= r_vec;
            end
            if (r_vec == 8'hFF) begin
              r_state <= S_DONE;
              r_vec   <= 8'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_cnt == 9'd0) && (w_mis == 4'd0);
            end else begin
              r_vec <= r_vec + 8'd1;
              r_cnt <= CNT_RELOAD;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_a_out      = w_a;
  assign o_b_out      = w_b;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail_mask  = r_fail_mask;
  assign o_first_fail = r_first_fail;
  assign o_err_cnt    = r_err_cnt;

endmodule
